// File: rtl/nibble_parity_frame_checker.sv
// Frame-level parity checker for a valid/ready stream of 4-bit nibbles.
// Accumulates per-nibble XOR parity and reports a one-entry result per frame.
module nibble_parity_frame_checker #(
    parameter int MAX_NIBBLES = 16,
    parameter int CW          = $clog2(MAX_NIBBLES + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_nibble,
    input  logic          in_last,
    input  logic          in_exp_parity,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_parity,
    output logic          out_error,
    output logic          out_overflow,
    output logic [CW-1:0] out_count
);

    // state    | meaning
    // S_IDLE   | waiting for the first beat of a frame
    // S_ACCUM  | mid-frame, folding beat parity into acc
    // S_REPORT | result held on the output port, input stalled
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            acc_q, acc_d;
    logic [CW-1:0]   count_q, count_d;
    logic            rdy_en_q, rdy_en_d;
    logic            res_parity_q, res_parity_d;
    logic            res_error_q, res_error_d;
    logic            res_overflow_q, res_overflow_d;
    logic [CW-1:0]   res_count_q, res_count_d;

    logic            beat_acc;
    logic            nib_par;
    logic [CW-1:0]   count_inc;
    logic            at_max;

    assign beat_acc  = in_valid & in_ready;
    assign nib_par   = ^in_nibble;
    assign count_inc = count_q + CW'(1);
    assign at_max    = (count_inc == CW'(MAX_NIBBLES));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            acc_q          <= 1'b0;
            count_q        <= '0;
            rdy_en_q       <= 1'b0;
            res_parity_q   <= 1'b0;
            res_error_q    <= 1'b0;
            res_overflow_q <= 1'b0;
            res_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            count_q        <= count_d;
            rdy_en_q       <= rdy_en_d;
            res_parity_q   <= res_parity_d;
            res_error_q    <= res_error_d;
            res_overflow_q <= res_overflow_d;
            res_count_q    <= res_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (beat_acc) begin
                    state_d = in_last ? S_REPORT : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (beat_acc && (in_last || at_max)) begin
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: result registers load on the edge that enters S_REPORT.
    always_comb begin
        rdy_en_d       = 1'b1;
        acc_d          = acc_q;
        count_d        = count_q;
        res_parity_d   = res_parity_q;
        res_error_d    = res_error_q;
        res_overflow_d = res_overflow_q;
        res_count_d    = res_count_q;
        case (state_q)
            S_IDLE: begin
                if (beat_acc) begin
                    acc_d   = nib_par;
                    count_d = CW'(1);
                    if (in_last) begin
                        res_parity_d   = nib_par;
                        res_error_d    = nib_par ^ in_exp_parity;
                        res_overflow_d = 1'b0;
                        res_count_d    = CW'(1);
                    end
                end
            end
            S_ACCUM: begin
                if (beat_acc) begin
                    acc_d   = acc_q ^ nib_par;
                    count_d = count_inc;
                    if (in_last) begin
                        res_parity_d   = acc_q ^ nib_par;
                        res_error_d    = acc_q ^ nib_par ^ in_exp_parity;
                        res_overflow_d = 1'b0;
                        res_count_d    = count_inc;
                    end else if (at_max) begin
                        res_parity_d   = acc_q ^ nib_par;
                        res_error_d    = 1'b1;
                        res_overflow_d = 1'b1;
                        res_count_d    = count_inc;
                    end
                end
            end
            S_REPORT: begin
                if (out_ready) begin
                    acc_d          = 1'b0;
                    count_d        = '0;
                    res_parity_d   = 1'b0;
                    res_error_d    = 1'b0;
                    res_overflow_d = 1'b0;
                    res_count_d    = '0;
                end
            end
            default: begin
                acc_d   = 1'b0;
                count_d = '0;
            end
        endcase
    end

    // in_ready waits one edge after reset release via rdy_en_q.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE, S_ACCUM: in_ready = rdy_en_q;
            S_REPORT:        out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    assign out_parity   = res_parity_q;
    assign out_error    = res_error_q;
    assign out_overflow = res_overflow_q;
    assign out_count    = res_count_q;

endmodule

// File: tb/tb_nibble_parity_frame_checker.sv
// Self-checking bench for nibble_parity_frame_checker: vector table,
// hand-written corner sequences and randomized frames against a frame model.
module tb_nibble_parity_frame_checker;

    localparam int MAXN = 16;
    localparam int CW   = $clog2(MAXN + 1);

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_nibble;
    logic          in_last;
    logic          in_exp_parity;
    logic          out_valid;
    logic          out_ready;
    logic          out_parity;
    logic          out_error;
    logic          out_overflow;
    logic [CW-1:0] out_count;

    int n_checks = 0;
    int n_fail   = 0;

    nibble_parity_frame_checker #(.MAX_NIBBLES(MAXN)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_nibble     (in_nibble),
        .in_last       (in_last),
        .in_exp_parity (in_exp_parity),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_parity    (out_parity),
        .out_error     (out_error),
        .out_overflow  (out_overflow),
        .out_count     (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          len;
        logic [63:0] nibs;
        logic        last;
        logic        exp;
        logic        e_par;
        logic        e_err;
        logic        e_ovf;
        int          e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one beat and wait (bounded) until it is accepted; returns at posedge+1.
    task automatic send_beat(input logic [3:0] nib, input logic last, input logic exp);
        int t = 0;
        in_valid = 1'b1;
        in_nibble = nib;
        in_last = last;
        in_exp_parity = exp;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_nibble = 'x;
        in_last = 1'b0;
        in_exp_parity = 1'b0;
    endtask

    task automatic chk_result(input string tag, input logic e_par, input logic e_err,
                              input logic e_ovf, input int e_cnt);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_parity"}, 32'(out_parity), 32'(e_par));
        chk({tag, "_error"}, 32'(out_error), 32'(e_err));
        chk({tag, "_ovf"}, 32'(out_overflow), 32'(e_ovf));
        chk({tag, "_count"}, 32'(out_count), 32'(e_cnt));
    endtask

    // Called at posedge+1 right after the closing beat: result must already be valid.
    task automatic get_result(input string tag, input int hold, input logic e_par,
                              input logic e_err, input logic e_ovf, input int e_cnt);
        chk_result(tag, e_par, e_err, e_ovf, e_cnt);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
            chk_result({tag, "_hold"}, e_par, e_err, e_ovf, e_cnt);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_consumed"}, 32'(out_valid), 32'd0);
        chk({tag, "_rdy_after"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_frame(input string tag, input int len, input logic [63:0] nibs,
                             input logic last, input logic exp, input int gap_max,
                             input int hold, input logic e_par, input logic e_err,
                             input logic e_ovf, input int e_cnt);
        for (int i = 0; i < len; i++) begin
            if (i > 0 && gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) @(negedge clk);
            end
            send_beat(nibs[4*i +: 4], last && (i == len - 1), exp);
        end
        get_result(tag, hold, e_par, e_err, e_ovf, e_cnt);
    endtask

    // Reference: frame parity is the count of set bits mod 2; overflow forces error.
    task automatic model(input int len, input logic [63:0] nibs, input logic last,
                         input logic exp, output logic par, output logic err,
                         output logic ovf);
        int ones = 0;
        for (int i = 0; i < len; i++) ones += $countones(nibs[4*i +: 4]);
        par = logic'(ones % 2);
        ovf = (len == MAXN) && !last;
        err = ovf ? 1'b1 : (par ^ exp);
    endtask

    initial begin
        logic [15:0] par_tbl;
        logic        m_par, m_err, m_ovf;
        int          len;
        logic [63:0] nibs;
        logic        last, exp;

        par_tbl = 16'b0110_1001_1001_0110;
        for (int i = 0; i < 16; i++) begin
            vecs.push_back('{1, 64'(i), 1'b1, par_tbl[i], par_tbl[i], 1'b0, 1'b0, 1});
        end
        vecs.push_back('{3, 64'h731, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3});
        vecs.push_back('{3, 64'h731, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3});
        vecs.push_back('{16, 64'h1111_1111_1111_1111, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16});
        vecs.push_back('{1, 64'h1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{16, 64'h1111_1111_1111_1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16});
        vecs.push_back('{16, 64'h7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16});
        vecs.push_back('{2, 64'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2});
        vecs.push_back('{5, 64'h84210, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5});

        reset_n = 1'b0;
        in_valid = 1'b0;
        in_nibble = 4'h0;
        in_last = 1'b0;
        in_exp_parity = 1'b0;
        out_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outs", {28'd0, out_parity, out_error, out_overflow, 1'b0} | 32'(out_count), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("rdy_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rdy_after_edge", 32'(in_ready), 32'd1);

        // First frame: single zero nibble.
        send_beat(4'h0, 1'b1, 1'b0);
        get_result("first", 0, 1'b0, 1'b0, 1'b0, 1);

        foreach (vecs[k]) begin
            run_frame($sformatf("vec%0d", k), vecs[k].len, vecs[k].nibs, vecs[k].last,
                      vecs[k].exp, 0, 0, vecs[k].e_par, vecs[k].e_err, vecs[k].e_ovf,
                      vecs[k].e_cnt);
        end

        // Backpressure with a pending beat during REPORT.
        send_beat(4'h1, 1'b0, 1'b0);
        send_beat(4'h3, 1'b0, 1'b0);
        send_beat(4'h7, 1'b1, 1'b1);
        in_valid = 1'b1;
        in_nibble = 4'hF;
        in_last = 1'b1;
        in_exp_parity = 1'b0;
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk_result("bp", 1'b0, 1'b1, 1'b0, 3);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_consumed", 32'(out_valid), 32'd0);
        chk("bp_rdy", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_nibble = 'x;
        in_last = 1'b0;
        get_result("bp_next", 0, 1'b0, 1'b0, 1'b0, 1);

        // Same frame with gaps (nibble is X while idle).
        run_frame("gaps", 3, 64'h731, 1'b1, 1'b1, 4, 0, 1'b0, 1'b1, 1'b0, 3);

        // Reset mid-frame.
        send_beat(4'h1, 1'b0, 1'b0);
        send_beat(4'h2, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        chk("midrst_ready_hold", 32'(in_ready), 32'd0);
        reset_n = 1'b1;
        run_frame("after_rst", 1, 64'h3, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1);

        // Reset during REPORT discards the result.
        send_beat(4'h1, 1'b1, 1'b0);
        chk("rptrst_pre", 32'(out_valid), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rptrst_valid", 32'(out_valid), 32'd0);
        chk("rptrst_outs", {28'd0, out_parity, out_error, out_overflow, 1'b0} | 32'(out_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_frame("after_rst2", 2, 64'h21, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 2);

        // Randomized frames against the model.
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, MAXN);
            nibs = {$urandom, $urandom};
            last = (len < MAXN) ? 1'b1 : logic'($urandom_range(0, 1));
            exp = logic'($urandom_range(0, 1));
            model(len, nibs, last, exp, m_par, m_err, m_ovf);
            run_frame($sformatf("rnd%0d", f), len, nibs, last, exp, 2,
                      $urandom_range(0, 3), m_par, m_err, m_ovf, len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/nibble_parity_frame_checker.md
Name: nibble_parity_frame_checker

Overview:
- Consumes a valid/ready stream of 4-bit nibbles grouped into frames; the last beat of each frame is marked by in_last.
- Computes each nibble's 4-input XOR parity and accumulates it across the frame.
- Compares the accumulated parity against the expected parity bit carried on the last beat.
- Presents a one-entry result (parity, error, overflow, beat count) on a valid/ready output port. This is the sequential stage directly downstream of the 4-input XOR parity cell.

Parameters:
- MAX_NIBBLES, default 16, maximum beats per frame (legal range 2..255).
- CW, default $clog2(MAX_NIBBLES+1), width of the beat counter and out_count (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat.
- in_nibble  input  4  data nibble {a,b,c,d}.
- in_last  input  1  final beat of frame.
- in_exp_parity  input  1  expected frame parity; sampled only on an accepted last beat.
- out_valid  output  1  result held.
- out_ready  input  1  downstream accepts result.
- out_parity  output  1  XOR of all bits of all nibbles in the frame.
- out_error  output  1  parity mismatch or overflow.
- out_overflow  output  1  frame closed at MAX_NIBBLES without in_last.
- out_count  output  CW  beats in the frame (1..MAX_NIBBLES).

Behaviour:
- Reset is one clock domain, asynchronous assert, active-low: reset_n is the single clock's asynchronous, active-low reset.
- While reset_n=0: state=IDLE, acc=0, count=0, in_ready=0. All out_* are 0.
- in_ready=1 from the first clk edge after reset_n deasserts.
- Handshakes:
  - An input beat is accepted when in_valid & in_ready at a rising edge.
  - A result is accepted when out_valid & out_ready.
  - Once out_valid is asserted, it and all out_* are held stable until accepted.
- Nibble parity: p = ^in_nibble (combinational, same cycle as acceptance).
- FSM, three states:
  - IDLE: in_ready=1, out_valid=0.
    - Accepted beat: acc<=p, count<=1.
    - If in_last, go to REPORT. Otherwise go to ACCUM.
  - ACCUM: in_ready=1, out_valid=0.
    - Accepted beat: acc<=acc^p, count<=count+1.
    - If in_last, go to REPORT.
    - Else if count+1==MAX_NIBBLES, go to REPORT with overflow.
    - Otherwise stay in ACCUM.
  - REPORT: in_ready=0, out_valid=1.
    - On out_ready, go to IDLE and clear acc and count.
- Result registers are loaded on the edge that enters REPORT, so out_valid rises the cycle after the closing beat:
  - out_parity = final acc.
  - out_count = final count.
  - Normal close: out_error = final acc ^ in_exp_parity; out_overflow=0.
  - Overflow close (MAX_NIBBLES beats, none with in_last): out_overflow=1; out_error=1 regardless of parity; in_exp_parity is ignored.
- A beat at exactly MAX_NIBBLES with in_last=1 is a normal close: out_overflow=0.
- After an overflow, the next accepted beat starts a new frame. No resynchronisation is attempted.
- Throughput:
  - A single-beat frame occupies 2 cycles: accept, then REPORT.
  - in_ready is low for every cycle spent in REPORT, so there is no input/output overlap and no back-to-back accept in REPORT.
  - Minimum frame spacing is N+1 cycles when out_ready=1.
- Input is ignored when in_valid=0; in_last and in_exp_parity are don't-care then.
- in_valid low mid-frame (gap): state and acc are held indefinitely.
- Reset asserted mid-frame or during REPORT: the frame and the result are discarded immediately; outputs return to reset values.
- X on in_nibble with in_valid=0 must not propagate into acc.

Test Plan:
- Reset, then a single beat with nibble 4'b0000, last=1, exp=0 -> out_valid one cycle later; parity=0, error=0, overflow=0, count=1.
- Single-beat frames sweeping all 16 nibbles with exp = expected 4-input XOR: parity matches the truth table (0001->1, 0011->0, 0111->1, 1111->0, ...); error=0 on every frame.
- Frame 4'h1, 4'h3, 4'h7 (last), exp=0 -> acc=1^0^1=0; parity=0, error=0, count=3. Repeat with exp=1 -> error=1.
- MAX_NIBBLES=16: 16 beats of 4'h1 with in_last never set -> after the 16th beat, overflow=1, error=1, count=16, parity=0. The next beat starts a fresh frame with count=1.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and outputs stable all 5 cycles. Raise out_ready -> result consumed, then the next beat is accepted the following cycle. Insert in_valid gaps mid-frame -> result is identical to the gap-free run.
- Assert reset_n=0 after 2 beats of a 4-beat frame -> out_valid=0 and in_ready=0 while reset is asserted. After release, a new 1-beat frame reports count=1 (no leftover beats).
